surf_buffer_scheduler: RTL
==========================

SURF_BUFFER_SCHEDULER -- requirements
Module: surf_buffer_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4095, max clk33_i cycles to wait for dig_done_i.
REQ-002 SHALL have parameter QDEPTH, default 4, pending-queue depth (one slot per LAB buffer).
REQ-003 clk33_i  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-004 rst_i  in  1  synchronous active-high reset, sampled on rising clk33_i.
REQ-005 event_id_wr_i  in  1  one-cycle strobe from command receiver: new trigger accepted.
REQ-006 event_id_buffer_i  in  2  buffer number for the strobed trigger.
REQ-007 event_id_i  in  32  event ID for the strobed trigger.
REQ-008 dig_start_o  out  1  one-cycle pulse: digitizer begins on dig_buffer_o.
REQ-009 dig_buffer_o  out  2  buffer being digitized; stable from dig_start_o until completion.
REQ-010 dig_event_id_o  out  32  event ID of buffer being digitized; same stability as dig_buffer_o.
REQ-011 dig_done_i  in  1  one-cycle pulse from digitizer: current buffer digitized.
REQ-012 rd_clear_i  in  1  one-cycle pulse from readout: buffer rd_buffer_i has been read.
REQ-013 rd_buffer_i  in  2  buffer number being released.
REQ-014 buffer_free_o  out  4  bit n high = buffer n FREE.
REQ-015 buffer_ready_o  out  4  bit n high = buffer n FULL (digitized, awaiting readout).
REQ-016 overrun_o  out  1  sticky: trigger arrived for a non-FREE buffer.
REQ-017 timeout_o  out  1  sticky: digitizer failed to finish within TIMEOUT_CYCLES.

Function
REQ-018 Each buffer SHALL hold one of FREE, PENDING, DIGITIZING, FULL.
REQ-019 event_id_wr_i on a FREE buffer SHALL mark it PENDING and push {buffer, ID} into the FIFO queue at the same edge.
REQ-020 event_id_wr_i on a non-FREE buffer SHALL be dropped (no queue push, state unchanged) and set overrun_o.
REQ-021 Queue SHALL be FIFO, depth QDEPTH; it cannot overflow because at most four buffers are non-FREE; pop on empty SHALL never occur.
REQ-022 Scheduler FSM states: IDLE, START, WAIT_DONE.
REQ-023 IDLE: if queue non-empty, pop head into dig_buffer_o/dig_event_id_o, mark buffer DIGITIZING, go START.
REQ-024 START: dig_start_o high this cycle only; clear timeout counter; go WAIT_DONE.
REQ-025 WAIT_DONE: on dig_done_i mark buffer FULL, go IDLE; else if counter reaches TIMEOUT_CYCLES mark buffer FREE, set timeout_o, go IDLE; else increment counter.
REQ-026 dig_done_i outside WAIT_DONE SHALL be ignored.
REQ-027 Latency: trigger sampled at edge N with scheduler IDLE and queue empty SHALL give dig_start_o high in cycle after edge N+2 (IDLE pops at N+1, START at N+2).
REQ-028 Back-to-back: after done, next queued buffer's dig_start_o SHALL follow 2 cycles after the done edge.
REQ-029 rd_clear_i on a FULL buffer SHALL mark it FREE; on any other state SHALL be ignored.
REQ-030 Same-cycle rd_clear_i and event_id_wr_i on the same FULL buffer: clear applies first, trigger accepted (buffer PENDING, no overrun).
REQ-031 Same-cycle dig_done_i and rd_clear_i of that buffer: buffer becomes FULL; clear ignored.
REQ-032 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES, no wrap before compare.

Reset
REQ-033 rst_i high SHALL, at the next edge, set all buffers FREE, empty the queue, FSM IDLE, counter 0.
REQ-034 Reset values: dig_start_o 0, dig_buffer_o 0, dig_event_id_o 0, buffer_free_o 4'hF, buffer_ready_o 0, overrun_o 0, timeout_o 0.
REQ-035 Reset mid-digitization SHALL abandon the buffer; a later dig_done_i SHALL be ignored.
REQ-036 Strobes coincident with rst_i SHALL be ignored.

Structure
REQ-037 Buffer-state encodings, FSM state encodings and buffer count (4) SHALL live in shared package surf_pkg.
REQ-038 The queue SHALL be a sub-module surf_sched_fifo (sync FIFO, push/pop/empty/full, width 34).

Verification
REQ-039 Trigger buf 2, ID 0x12345678 at edge 0 -> dig_start_o pulse after edge 2, dig_buffer_o=2, dig_event_id_o=0x12345678, buffer_free_o=4'hB.
REQ-040 Triggers buf 0,1,2,3 on consecutive cycles, dig_done_i 10 cycles after each start -> four starts in order 0,1,2,3, buffer_ready_o=4'hF, buffer_free_o=0.
REQ-041 Second trigger to buf 1 while PENDING -> overrun_o=1, only one start for buf 1.
REQ-042 TIMEOUT_CYCLES=8, no dig_done_i -> timeout_o=1 after 8 WAIT_DONE cycles, buffer FREE, next queued buffer starts.
REQ-043 Buf 0 FULL; rd_clear_i and event_id_wr_i buf 0 same cycle -> buffer_ready_o[0]=0, new start for buf 0, overrun_o=0.
REQ-044 rst_i during WAIT_DONE then dig_done_i -> all outputs at reset values, buffer_ready_o stays 0.

Source files
------------

// File: rtl/surf_pkg.sv
// Shared types for the SURF LAB buffer scheduler: buffer/FSM encodings,
// queue entry layout and a small state-to-bitmask helper.
package surf_pkg;

    localparam int NUM_BUFS = 4;
    localparam int BUF_W    = 2;
    localparam int EVID_W   = 32;
    localparam int QWIDTH   = BUF_W + EVID_W;

    typedef enum logic [1:0] {
        BUF_FREE       = 2'd0,
        BUF_PENDING    = 2'd1,
        BUF_DIGITIZING = 2'd2,
        BUF_FULL       = 2'd3
    } buf_state_e;

    typedef enum logic [1:0] {
        SCH_IDLE      = 2'd0,
        SCH_START     = 2'd1,
        SCH_WAIT_DONE = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [BUF_W-1:0]  buffer;
        logic [EVID_W-1:0] event_id;
    } q_entry_t;

    function automatic logic [NUM_BUFS-1:0] state_mask(input buf_state_e st [NUM_BUFS],
                                                       input buf_state_e want);
        logic [NUM_BUFS-1:0] mask;
        for (int i = 0; i < NUM_BUFS; i++) begin
            mask[i] = (st[i] == want);
        end
        return mask;
    endfunction

endpackage

// File: rtl/surf_buffer_scheduler_if.sv
// Trigger, digitizer and readout signals of the buffer scheduler.
interface surf_buffer_scheduler_if;

    logic        event_id_wr_i;
    logic [1:0]  event_id_buffer_i;
    logic [31:0] event_id_i;
    logic        dig_start_o;
    logic [1:0]  dig_buffer_o;
    logic [31:0] dig_event_id_o;
    logic        dig_done_i;
    logic        rd_clear_i;
    logic [1:0]  rd_buffer_i;
    logic [3:0]  buffer_free_o;
    logic [3:0]  buffer_ready_o;
    logic        overrun_o;
    logic        timeout_o;

    modport master (
        output event_id_wr_i, event_id_buffer_i, event_id_i, dig_done_i, rd_clear_i, rd_buffer_i,
        input  dig_start_o, dig_buffer_o, dig_event_id_o, buffer_free_o, buffer_ready_o,
               overrun_o, timeout_o
    );

    modport slave (
        input  event_id_wr_i, event_id_buffer_i, event_id_i, dig_done_i, rd_clear_i, rd_buffer_i,
        output dig_start_o, dig_buffer_o, dig_event_id_o, buffer_free_o, buffer_ready_o,
               overrun_o, timeout_o
    );

endinterface

// File: rtl/surf_sched_fifo.sv
// Small synchronous FIFO holding pending {buffer, event ID} entries.
module surf_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clk33_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign empty     = (count_r == {(PW + 1){1'b0}});
    assign full      = (count_r == DEPTH_CNT);
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/surf_buffer_scheduler.sv
// Tracks the four LAB buffers, queues accepted triggers and hands them to the
// digitizer one at a time, with a watchdog on each digitization.
module surf_buffer_scheduler #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int QDEPTH         = 4
) (
    input  logic                    clk33_i,
    input  logic                    rst_i,
    surf_buffer_scheduler_if.slave  bus
);

    import surf_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_e        state_r, state_nxt_s;
    buf_state_e          buf_r [NUM_BUFS];
    buf_state_e          buf_nxt_s [NUM_BUFS];
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [BUF_W-1:0]    dig_buf_r, dig_buf_nxt_s;
    logic [EVID_W-1:0]   dig_id_r, dig_id_nxt_s;
    logic                dig_start_r;
    logic [NUM_BUFS-1:0] free_r, ready_r;
    logic                overrun_r, timeout_r;
    logic                push_s, pop_s, q_empty_s, q_full_s;
    logic                clr_hit_s, trig_ok_s, overrun_set_s, timeout_set_s;
    q_entry_t            q_head_s, q_tail_s;

    assign q_tail_s = '{buffer: bus.event_id_buffer_i, event_id: bus.event_id_i};

    surf_sched_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (QWIDTH)
    ) u_fifo (
        .clk33_i (clk33_i),
        .rst_i   (rst_i),
        .push    (push_s),
        .pop     (pop_s),
        .din     (q_tail_s),
        .dout    (q_head_s),
        .empty   (q_empty_s),
        .full    (q_full_s)
    );

    // Next buffer states and scheduler step; a readout clear is resolved before
    // the trigger so a just-freed buffer can be re-armed in the same cycle.
    always_comb begin
        buf_nxt_s     = buf_r;
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        dig_buf_nxt_s = dig_buf_r;
        dig_id_nxt_s  = dig_id_r;
        pop_s         = 1'b0;
        push_s        = 1'b0;
        overrun_set_s = 1'b0;
        timeout_set_s = 1'b0;

        clr_hit_s = bus.rd_clear_i && (buf_r[bus.rd_buffer_i] == BUF_FULL);
        trig_ok_s = (buf_r[bus.event_id_buffer_i] == BUF_FREE) ||
                    (clr_hit_s && (bus.rd_buffer_i == bus.event_id_buffer_i));

        if (clr_hit_s) begin
            buf_nxt_s[bus.rd_buffer_i] = BUF_FREE;
        end else begin
            buf_nxt_s[bus.rd_buffer_i] = buf_nxt_s[bus.rd_buffer_i];
        end

        case (state_r)
            SCH_IDLE: begin
                if (!q_empty_s) begin
                    pop_s                      = 1'b1;
                    dig_buf_nxt_s              = q_head_s.buffer;
                    dig_id_nxt_s               = q_head_s.event_id;
                    buf_nxt_s[q_head_s.buffer] = BUF_DIGITIZING;
                    state_nxt_s                = SCH_START;
                end else begin
                    state_nxt_s = SCH_IDLE;
                end
            end
            SCH_START: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = SCH_WAIT_DONE;
            end
            SCH_WAIT_DONE: begin
                if (bus.dig_done_i) begin
                    buf_nxt_s[dig_buf_r] = BUF_FULL;
                    state_nxt_s          = SCH_IDLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    buf_nxt_s[dig_buf_r] = BUF_FREE;
                    timeout_set_s        = 1'b1;
                    state_nxt_s          = SCH_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = SCH_IDLE;
            end
        endcase

        if (bus.event_id_wr_i) begin
            if (trig_ok_s && !q_full_s) begin
                buf_nxt_s[bus.event_id_buffer_i] = BUF_PENDING;
                push_s                           = 1'b1;
            end else begin
                overrun_set_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_r     <= SCH_IDLE;
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_r[i] <= BUF_FREE;
            end
            cnt_r       <= {CNT_W{1'b0}};
            dig_buf_r   <= {BUF_W{1'b0}};
            dig_id_r    <= {EVID_W{1'b0}};
            dig_start_r <= 1'b0;
            free_r      <= {NUM_BUFS{1'b1}};
            ready_r     <= {NUM_BUFS{1'b0}};
            overrun_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            buf_r       <= buf_nxt_s;
            cnt_r       <= cnt_nxt_s;
            dig_buf_r   <= dig_buf_nxt_s;
            dig_id_r    <= dig_id_nxt_s;
            dig_start_r <= (state_r == SCH_START);
            free_r      <= state_mask(buf_nxt_s, BUF_FREE);
            ready_r     <= state_mask(buf_nxt_s, BUF_FULL);
            overrun_r   <= overrun_r | overrun_set_s;
            timeout_r   <= timeout_r | timeout_set_s;
        end
    end

    assign bus.dig_start_o    = dig_start_r;
    assign bus.dig_buffer_o   = dig_buf_r;
    assign bus.dig_event_id_o = dig_id_r;
    assign bus.buffer_free_o  = free_r;
    assign bus.buffer_ready_o = ready_r;
    assign bus.overrun_o      = overrun_r;
    assign bus.timeout_o      = timeout_r;

endmodule
